two_power_mod: RTL and testbench



---
 rtl/two_power_mod.sv | 123 ++++++++++++
 tb/tb_two_power_mod.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/two_power_mod.sv
// two_power_mod: computes o_out = 2^i_power mod i_modulus. This is the
// Montgomery pre-scaling constant (R^2 mod N when i_power = 2*MOD_WIDTH).
// The datapath is iterative shift/conditional-subtract and does one doubling
// step per cycle. Both sides use valid/ready handshakes.
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset
//   i_valid   request valid
//   i_ready   block can accept a request (high only in IDLE)
//   i_power   exponent k, sampled only at the accept edge
//   i_modulus modulus N, sampled only at the accept edge
//   o_valid   result valid (DONE state)
//   o_ready   downstream accepts result
//   o_out     2^k mod N, held stable while o_valid && !o_ready, 0 otherwise
module two_power_mod #(
  parameter int unsigned MOD_WIDTH   = 256,
  parameter int unsigned POWER_WIDTH = $clog2(2*MOD_WIDTH+1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [POWER_WIDTH-1:0] i_power,
  input  logic [MOD_WIDTH-1:0]   i_modulus,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [MOD_WIDTH-1:0]   o_out
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [POWER_WIDTH-1:0] r_cnt;
  logic [POWER_WIDTH-1:0] r_k;
  logic [MOD_WIDTH-1:0]   r_n;
  logic [MOD_WIDTH-1:0]   r_x;

  logic [POWER_WIDTH-1:0] w_cnt_inc;
  logic [MOD_WIDTH:0]     w_t;
  logic [MOD_WIDTH-1:0]   w_sub;
  logic [MOD_WIDTH-1:0]   w_x_step;
  logic                   w_last;

  // Doubling step. Because x < N always holds, 2x < 2N, so a single
  // conditional subtract is enough. The subtraction only needs the low
  // MOD_WIDTH bits: when t >= N the true difference fits in MOD_WIDTH bits.
  assign w_cnt_inc = r_cnt + POWER_WIDTH'(1);
  assign w_t       = {r_x, 1'b0};
  assign w_sub     = w_t[MOD_WIDTH-1:0] - r_n;
  assign w_x_step  = (w_t >= {1'b0, r_n}) ? w_sub : w_t[MOD_WIDTH-1:0];
  assign w_last    = (w_cnt_inc == r_k);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    i_ready     = 1'b0;
    o_valid     = 1'b0;
    o_out       = '0;
    case (r_state)
      IDLE: begin
        i_ready = 1'b1;
        if (i_valid) begin
          w_state_nxt = (i_power == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        o_valid = 1'b1;
        o_out   = r_x;
        if (o_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_k   <= '0;
      r_n   <= '0;
      r_x   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_n   <= i_modulus;
            r_k   <= i_power;
            r_cnt <= '0;
            // Moduli 0 and 1 give 0 for every k; x stays 0 through RUN.
            r_x   <= (i_modulus >= MOD_WIDTH'(2)) ? MOD_WIDTH'(1) : '0;
          end
        end
        RUN: begin
          r_cnt <= w_cnt_inc;
          if (r_n >= MOD_WIDTH'(2)) begin
            r_x <= w_x_step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_two_power_mod.sv
// Testbench for two_power_mod: directed vectors with hand-computed results,
// plus sequences for backpressure, back-to-back requests and mid-run reset.
module tb_two_power_mod;

  localparam int unsigned MW = 256;
  localparam int unsigned PW = 10;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic          i_ready;
  logic [PW-1:0] i_power;
  logic [MW-1:0] i_modulus;
  logic          o_valid;
  logic          o_ready;
  logic [MW-1:0] o_out;

  two_power_mod #(.MOD_WIDTH(MW), .POWER_WIDTH(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_power   (i_power),
    .i_modulus (i_modulus),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_out     (o_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [PW-1:0] k;
    logic [MW-1:0] n;
    logic [MW-1:0] exp;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request, measure latency in cycles after the accept edge,
  // check the result, then complete the output handshake.
  task automatic run_vec(input logic [PW-1:0] k, input logic [MW-1:0] n, input logic [MW-1:0] exp);
    int lat;
    int wait_c;
    bit busy_ok;
    wait_c = 0;
    @(negedge clk);
    while (!i_ready && wait_c < 20) begin
      @(negedge clk);
      wait_c++;
    end
    check("ready_before_req", {255'b0, i_ready}, 256'd1);
    i_valid   = 1'b1;
    i_power   = k;
    i_modulus = n;
    @(posedge clk);
    @(negedge clk);
    i_valid   = 1'b0;
    i_power   = $urandom_range(0, 1023);
    i_modulus = {8{$urandom()}};
    lat     = 1;
    busy_ok = 1'b1;
    while (!o_valid && lat < int'(k) + 20) begin
      if (i_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (i_ready) busy_ok = 1'b0;
    check("latency", 256'(lat), 256'(int'(k) + 1));
    check("result", o_out, exp);
    check("busy_no_ready", {255'b0, busy_ok}, 256'd1);
    o_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    o_ready = 1'b0;
    check("valid_after_hs", {255'b0, o_valid}, 256'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MW-1:0] all1;
    logic [MW-1:0] q_res [$];
    int cyc;
    int acc_cyc [$];
    int bad;
    bit drop;

    all1 = '1;
    vecs[0]  = '{k: 10'd4,   n: 256'd13,                        exp: 256'd3};
    vecs[1]  = '{k: 10'd0,   n: 256'd13,                        exp: 256'd1};
    vecs[2]  = '{k: 10'd512, n: all1,                           exp: 256'd1};
    vecs[3]  = '{k: 10'd256, n: {1'b1, 254'b0, 1'b1},           exp: {1'b0, {255{1'b1}}}};
    vecs[4]  = '{k: 10'd7,   n: 256'd1,                         exp: 256'd0};
    vecs[5]  = '{k: 10'd3,   n: 256'd0,                         exp: 256'd0};
    vecs[6]  = '{k: 10'd10,  n: 256'd11,                        exp: 256'd1};
    vecs[7]  = '{k: 10'd600, n: all1,                           exp: 256'd1 << 88};
    vecs[8]  = '{k: 10'd1,   n: 256'd2,                         exp: 256'd0};
    vecs[9]  = '{k: 10'd5,   n: 256'd3,                         exp: 256'd2};
    vecs[10] = '{k: 10'd0,   n: 256'd1,                         exp: 256'd0};

    rst_n     = 1'b0;
    i_valid   = 1'b0;
    i_power   = '0;
    i_modulus = '0;
    o_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_o_valid", {255'b0, o_valid}, 256'd0);
    check("rst_i_ready", {255'b0, i_ready}, 256'd1);
    check("rst_o_out", o_out, 256'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i].k, vecs[i].n, vecs[i].exp);
    end

    // Backpressure: 8 mod 5 = 3, held for 10 cycles.
    @(negedge clk);
    i_valid = 1'b1; i_power = 10'd3; i_modulus = 256'd5;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0; i_modulus = 256'd7;
    cyc = 0;
    while (!o_valid && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (!o_valid || o_out !== 256'd3 || i_ready) bad++;
      @(negedge clk);
    end
    check("bp_stable_bad_cycles", 256'(bad), 256'd0);
    check("bp_result", o_out, 256'd3);
    o_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    o_ready = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (o_valid) bad++;
      @(negedge clk);
    end
    check("bp_single_hs", 256'(bad), 256'd0);

    // Back-to-back with o_ready held high.
    o_ready = 1'b1;
    i_valid = 1'b1; i_power = 10'd4; i_modulus = 256'd13;
    drop = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (o_valid) q_res.push_back(o_out);
      if (i_valid && i_ready) begin
        acc_cyc.push_back(c);
        if (acc_cyc.size() == 1) begin
          @(negedge clk);
          i_power = 10'd10; i_modulus = 256'd11;
          continue;
        end else begin
          drop = 1'b1;
        end
      end
      @(negedge clk);
      if (drop) i_valid = 1'b0;
    end
    i_valid = 1'b0;
    o_ready = 1'b0;
    check("b2b_count", 256'(q_res.size()), 256'd2);
    check("b2b_first", (q_res.size() > 0) ? q_res[0] : all1, 256'd3);
    check("b2b_second", (q_res.size() > 1) ? q_res[1] : all1, 256'd1);
    check("b2b_accept_gap", (acc_cyc.size() > 1) ? 256'(acc_cyc[1] - acc_cyc[0]) : all1, 256'd6);

    // Reset in the middle of a long run.
    @(negedge clk);
    i_valid = 1'b1; i_power = 10'd512; i_modulus = all1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_o_valid", {255'b0, o_valid}, 256'd0);
    check("midrst_i_ready", {255'b0, i_ready}, 256'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      if (o_valid) bad++;
      @(negedge clk);
    end
    check("midrst_no_pulse", 256'(bad), 256'd0);
    run_vec(10'd4, 256'd13, 256'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
